// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-generation pipeline: format selects
// and shift-amount field widths.
package imm_pkg;

  typedef enum logic [2:0] {
    SEL_I       = 3'b000,
    SEL_S       = 3'b001,
    SEL_B       = 3'b010,
    SEL_U       = 3'b011,
    SEL_J       = 3'b100,
    SEL_SHAMT   = 3'b101,
    SEL_ZIMM    = 3'b110,
    SEL_ILLEGAL = 3'b111
  } imm_sel_t;

  localparam int unsigned SHAMT_W32 = 5;
  localparam int unsigned SHAMT_W64 = 6;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Upstream offer and downstream result handshake of imm_gen_pipe.
// slave is the pipeline side, master the producer/consumer side.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_immsrc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_instr, in_immsrc, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_instr, in_immsrc, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_err
  );
endinterface

// File: rtl/imm_stage.sv
// One valid/ready register slice with synchronous flush; loads whenever it
// is empty or its content is being taken downstream.
module imm_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_load,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ds_ready
);
  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  assign w_load = !r_valid || i_ds_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

  assign o_load  = w_load;
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage RISC-V immediate generator: S1 holds the assembled 32-bit field
// plus sign/error flags, S2 holds the XLEN-extended result.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  imm_gen_pipe_if.slave bus
);
  import imm_pkg::*;

  localparam int unsigned SHAMT_W = (XLEN == 64) ? SHAMT_W64 : SHAMT_W32;
  localparam int unsigned S1_W    = 32 + 2 + TAG_W;
  localparam int unsigned S2_W    = XLEN + 1 + TAG_W;

  logic [31:0]      w_ins;
  logic [6:0]       w_unused_opcode;
  logic [31:0]      w_field;
  logic             w_sext;
  logic             w_err;
  logic             w_s1_load, w_s1_valid, w_s2_load;
  logic [S1_W-1:0]  w_s1_data;
  logic [31:0]      w_s1_field;
  logic             w_s1_sext, w_s1_err;
  logic [TAG_W-1:0] w_s1_tag;
  logic [XLEN-1:0]  w_ext;
  logic [S2_W-1:0]  w_s2_data;

  assign w_ins           = bus.in_instr;
  assign w_unused_opcode = w_ins[6:0];

  always_comb begin
    w_field = '0;
    w_sext  = 1'b0;
    w_err   = 1'b0;
    case (imm_sel_t'(bus.in_immsrc))
      SEL_I:     begin w_field = {{20{w_ins[31]}}, w_ins[31:20]}; w_sext = 1'b1; end
      SEL_S:     begin w_field = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]}; w_sext = 1'b1; end
      SEL_B:     begin
        w_field = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
        w_sext  = 1'b1;
      end
      SEL_U:     begin w_field = {w_ins[31:12], 12'b0}; w_sext = 1'b1; end
      SEL_J:     begin
        w_field = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
        w_sext  = 1'b1;
      end
      SEL_SHAMT: w_field = 32'(w_ins[20 +: SHAMT_W]);
      SEL_ZIMM:  w_field = {27'b0, w_ins[19:15]};
      default:   w_err = 1'b1;
    endcase
  end

  imm_stage #(.W(S1_W)) u_s1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_valid    (bus.in_valid),
    .o_load     (w_s1_load),
    .i_data     ({w_field, w_sext, w_err, bus.in_tag}),
    .o_valid    (w_s1_valid),
    .o_data     (w_s1_data),
    .i_ds_ready (w_s2_load)
  );

  assign {w_s1_field, w_s1_sext, w_s1_err, w_s1_tag} = w_s1_data;

  // The sign flag only matters when the field must be widened beyond 32 bits.
  generate
    if (XLEN == 64) begin : g_x64
      assign w_ext = {{32{w_s1_sext & w_s1_field[31]}}, w_s1_field};
    end else if (XLEN == 32) begin : g_x32
      logic w_unused_sext;
      assign w_unused_sext = w_s1_sext;
      assign w_ext         = w_s1_field;
    end else begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  imm_stage #(.W(S2_W)) u_s2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_valid    (w_s1_valid),
    .o_load     (w_s2_load),
    .i_data     ({w_ext, w_s1_err, w_s1_tag}),
    .o_valid    (bus.out_valid),
    .o_data     (w_s2_data),
    .i_ds_ready (bus.out_ready)
  );

  assign {bus.out_imm, bus.out_err, bus.out_tag} = w_s2_data;

  assign bus.in_ready = rst_n & (flush | w_s1_load);
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives XLEN=32 and XLEN=64 instances with identical traffic and checks both
// against a transaction-level model of the two-entry pipeline.
module tb_imm_gen_pipe;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [31:0]   in_instr = '0;
  logic [2:0]    in_immsrc = '0;
  logic [TW-1:0] in_tag = '0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(TW)) if32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(TW)) if64 ();

  assign if32.in_valid  = in_valid;
  assign if32.in_instr  = in_instr;
  assign if32.in_immsrc = in_immsrc;
  assign if32.in_tag    = in_tag;
  assign if32.out_ready = out_ready;
  assign if64.in_valid  = in_valid;
  assign if64.in_instr  = in_instr;
  assign if64.in_immsrc = in_immsrc;
  assign if64.in_tag    = in_tag;
  assign if64.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TW)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if32.slave));
  imm_gen_pipe #(.XLEN(64), .TAG_W(TW)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if64.slave));

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b1;

  typedef struct {
    logic [31:0]   ins;
    logic [2:0]    sel;
    logic [TW-1:0] tag;
    int            vis;
  } ent_t;

  ent_t          q[$];
  logic [TW-1:0] obs[$];

  // Immediate value straight from the ISA field definitions, in 64-bit
  // arithmetic; the 32-bit result is the low half.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel,
                                          input int xlen);
    longint s, u, r;
    s = longint'($signed(ins));
    u = longint'({32'b0, ins});
    case (sel)
      3'd0: r = s >>> 20;
      3'd1: r = ((s >>> 25) << 5) | ((u >> 7) & 31);
      3'd2: r = ((s >>> 31) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5)
               | (((u >> 8) & 15) << 1);
      3'd3: r = (s >>> 12) << 12;
      3'd4: r = ((s >>> 31) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11)
               | (((u >> 21) & 1023) << 1);
      3'd5: r = (xlen == 64) ? ((u >> 20) & 63) : ((u >> 20) & 31);
      3'd6: r = (u >> 15) & 31;
      default: r = 0;
    endcase
    if (xlen == 32) r = r & 64'h0000_0000_FFFF_FFFF;
    return 64'(r);
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: queue of in-flight entries; an entry is visible one edge after
  // capture, or at the edge its predecessor leaves, whichever is later.
  always @(posedge clk) begin
    ent_t e;
    bit   ev, er;
    int   now;
    now = cyc;
    cyc++;
    if (rst_n) begin
      ev = (q.size() > 0) && (now >= q[0].vis);
      er = flush || (q.size() < 2) || out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (ev && out_ready) begin
          void'(q.pop_front());
          if (q.size() > 0 && q[0].vis < cyc) q[0].vis = cyc;
        end
        if (er && in_valid) begin
          e.ins = in_instr;
          e.sel = in_immsrc;
          e.tag = in_tag;
          e.vis = cyc + 1;
          q.push_back(e);
        end
      end
    end
  end

  always @(negedge rst_n) q.delete();

  always @(negedge clk) begin
    bit ev, er;
    if (mon_en) begin
      if (!rst_n) begin
        check("rst_in_ready32", if32.in_ready, 0);
        check("rst_in_ready64", if64.in_ready, 0);
        check("rst_valid32", if32.out_valid, 0);
        check("rst_valid64", if64.out_valid, 0);
        check("rst_imm32", if32.out_imm, 0);
        check("rst_imm64", if64.out_imm, 0);
        check("rst_tag32", if32.out_tag, 0);
        check("rst_err64", if64.out_err, 0);
      end else begin
        ev = (q.size() > 0) && (cyc >= q[0].vis);
        er = flush || (q.size() < 2) || out_ready;
        check("in_ready32", if32.in_ready, er);
        check("in_ready64", if64.in_ready, er);
        check("out_valid32", if32.out_valid, ev);
        check("out_valid64", if64.out_valid, ev);
        if (ev) begin
          check("imm32", if32.out_imm, ref_imm(q[0].ins, q[0].sel, 32));
          check("imm64", if64.out_imm, ref_imm(q[0].ins, q[0].sel, 64));
          check("tag32", if32.out_tag, q[0].tag);
          check("tag64", if64.out_tag, q[0].tag);
          check("err32", if32.out_err, q[0].sel == 3'd7);
          check("err64", if64.out_err, q[0].sel == 3'd7);
        end
      end
      if (rst_n && !flush && if32.out_valid && out_ready) obs.push_back(if32.out_tag);
    end
  end

  task automatic directed(input logic [31:0] ins, input logic [2:0] sel, input logic [31:0] e32,
                          input logic [63:0] e64, input logic eerr);
    check("model32", ref_imm(ins, sel, 32), {32'b0, e32});
    check("model64", ref_imm(ins, sel, 64), e64);
    in_instr = ins; in_immsrc = sel; in_tag = 4'hA; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_early_valid", if32.out_valid, 0);
    @(negedge clk);
    check("lat_valid32", if32.out_valid, 1);
    check("lat_valid64", if64.out_valid, 1);
    check("dir_imm32", if32.out_imm, e32);
    check("dir_imm64", if64.out_imm, e64);
    check("dir_err", if32.out_err, eerr);
    step();
  endtask

  task automatic offer(input logic [TW-1:0] t);
    in_instr = $urandom; in_immsrc = 3'($urandom_range(0, 6)); in_tag = t; in_valid = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk); #2 rst_n = 1'b1;
    step();

    directed(32'hFFF00093, 3'b000, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    directed(32'hFE000EE3, 3'b010, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    directed(32'h800000B7, 3'b011, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    directed(32'h03F09093, 3'b101, 32'd31, 64'd63, 1'b0);
    directed(32'h03F09093, 3'b111, 32'd0, 64'd0, 1'b1);
    directed(32'h000F8073, 3'b110, 32'd31, 64'd31, 1'b0);

    // Back-pressure: third offer must be refused while tag 1 is held.
    obs.delete();
    out_ready = 1'b0;
    offer(1); step();
    offer(2); step();
    offer(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", if32.in_ready, 0);
      check("bp_tag_hold", if32.out_tag, 1);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    check("bp_count", obs.size(), 3);
    if (obs.size() == 3) begin
      check("bp_order0", obs[0], 1);
      check("bp_order1", obs[1], 2);
      check("bp_order2", obs[2], 3);
    end

    // Flush with both stages full and a simultaneous offer.
    obs.delete();
    out_ready = 1'b0;
    offer(4); step();
    offer(5); step();
    offer(6); flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", if32.in_ready, 1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", if32.out_valid, 0);
    step();
    out_ready = 1'b1;
    offer(7); step();
    in_valid = 1'b0;
    repeat (4) step();
    check("flush_count", obs.size(), 1);
    if (obs.size() == 1) check("flush_tag", obs[0], 7);

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    offer(8); step();
    offer(9); step();
    in_valid = 1'b0;
    step();
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid32", if32.out_valid, 0);
    check("arst_valid64", if64.out_valid, 0);
    check("arst_imm32", if32.out_imm, 0);
    check("arst_imm64", if64.out_imm, 0);
    repeat (2) step();
    @(negedge clk); #2 rst_n = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1; in_tag = 4'h5;
    step();

    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = $urandom;
      in_immsrc = 3'($urandom_range(0, 7));
      in_tag    = TW'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32: result width; legal values are 32 and 64 only.
REQ-002 Parameter TAG_W, default 4: width of the sideband tag carried unchanged through the pipe; minimum 1.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous kill of all in-flight entries.
REQ-006 in_valid  input  1  upstream offers an instruction.
REQ-007 in_ready  output  1  block accepts the offer this cycle.
REQ-008 in_instr  input  32  instruction word; bits 6:0 are ignored.
REQ-009 in_immsrc  input  3  immediate format select.
REQ-010 in_tag  input  TAG_W  opaque sideband.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream consumes the result this cycle.
REQ-013 out_imm  output  XLEN  extended immediate.
REQ-014 out_tag  output  TAG_W  tag of the result.
REQ-015 out_err  output  1  result came from an illegal select.

Function
REQ-016 in_immsrc encodings: 000 I, 001 S, 010 B, 011 U, 100 J, 101 shamt, 110 CSR zimm, 111 illegal.
REQ-017 I, S, B, J: standard RV field assembly, sign-extended from instr[31] to XLEN.
REQ-018 U: {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
REQ-019 shamt: instr[24:20] zero-extended when XLEN=32; instr[25:20] zero-extended when XLEN=64.
REQ-020 CSR zimm: instr[19:15] zero-extended.
REQ-021 illegal: out_imm all zeros, out_err=1; out_err=0 for every other select.
REQ-022 Stage S1 registers the 32-bit assembled field, the sign/zero flag, the error flag and the tag; stage S2 registers the XLEN-extended result.
REQ-023 Latency: an accepted input appears on out_valid on the 2nd rising edge after acceptance when unstalled.
REQ-024 Throughput: one transfer per cycle when out_ready is held high.
REQ-025 Transfer rule: a transfer occurs when valid and ready are both high on the same edge.
REQ-026 Stage advance rule: S2 loads when S2 is empty or out_ready=1; S1 loads when S1 is empty or S1 advances; in_ready equals the S1 load condition.
REQ-027 While out_valid=1 and out_ready=0, out_imm, out_tag and out_err are held stable.
REQ-028 Back-pressure holds at most 2 entries: in_ready=0 when both stages are full and out_ready=0.
REQ-029 in_ready is combinational from out_ready and internal state only, never from in_valid.
REQ-030 When flush=1, both valid bits clear on the next edge, and any input offered in that cycle is discarded.
REQ-031 in_ready=1 during flush.
REQ-032 flush has priority over simultaneous accept and consume.
REQ-033 No X shall reach any output for any in_immsrc value.

Reset
REQ-034 rst_n low asynchronously clears both valid bits and zeroes all data registers, giving out_valid=0, out_imm=0, out_tag=0 and out_err=0.
REQ-035 While rst_n is low, in_ready=0.
REQ-036 Reset asserted mid-transfer discards all in-flight entries; the first acceptance occurs on the first edge after rst_n is released.

Structure
REQ-037 Shared package imm_pkg holds the imm_sel_t enum for the REQ-016 encodings and the constants SHAMT_W32=5 and SHAMT_W64=6.
REQ-038 One sub-module, imm_stage, is a parametrised valid/ready register slice with flush, instantiated for S1 and S2.
REQ-039 Field assembly and extension are combinational logic inside imm_gen_pipe.

Verification
REQ-040 XLEN=32, instr 32'hFFF00093, sel 000, out_ready=1 -> out_imm 32'hFFFFFFFF and out_err=0, 2 cycles after acceptance.
REQ-041 XLEN=32, instr 32'hFE000EE3, sel 010 -> out_imm 32'hFFFFFFFC; XLEN=64, instr 32'h800000B7, sel 011 -> out_imm 64'hFFFFFFFF80000000.
REQ-042 XLEN=64, instr 32'h03F09093, sel 101 -> out_imm 63; the same stimulus at XLEN=32 -> out_imm 31; sel 111 -> out_imm 0 and out_err=1.
REQ-043 out_ready=0 with tags 1, 2, 3 offered back to back -> tags 1 and 2 accepted, in_ready=0 on the 3rd, out_tag stable at 1; release out_ready -> tags 1, 2, 3 emerge in order with no loss or duplication.
REQ-044 Both stages full, flush pulsed together with in_valid=1 -> out_valid=0 the next cycle, no offered tag ever emerges, and the next accepted input emerges normally.
REQ-045 rst_n dropped asynchronously with both stages full -> out_valid falls immediately and out_imm=0.
